// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: PC generator, in-flight tracker and a
// {pc, instr} FIFO feeding decode, with redirect flush and halt.
// Ports: clk/reset, imem_req/imem_addr/imem_rdata to the synchronous imem,
// redirect/redirect_pc/halt controls, id_ready/id_valid/id_pc/id_instr to
// decode, and count/full/empty occupancy status.
module fetch_queue #(
  parameter int PC_W = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  inflight_pc;
  logic             inflight;
  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [INS_W-1:0] ins_mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [PC_W-1:0]  target;
  logic [CW:0]      occ;
  logic             pop;
  logic             push;

  assign target = redirect_pc & ~PC_W'(3);

  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign id_valid = !empty && !redirect;
  assign id_pc = empty ? '0 : pc_mem[rptr];
  assign id_instr = empty ? '0 : ins_mem[rptr];

  assign pop = id_valid && id_ready;
  assign push = inflight && !redirect;

  // Credit check: every outstanding response must already own a slot.
  // A redirect drops the queue and the in-flight response, so it sees 0.
  always_comb begin
    occ = '0;
    if (!redirect)
      occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  end

  assign imem_req = !reset && !halt && (occ < (CW+1)'(DEPTH));
  assign imem_addr = redirect ? target : fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_req;
      inflight_pc <= imem_addr;
      if (imem_req)
        fetch_pc <= imem_addr + PC_W'(4);
      else if (redirect)
        fetch_pc <= target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wptr] <= inflight_pc;
      ins_mem[wptr] <= imem_rdata;
    end
  end

endmodule
